// File: rtl/dadda_mac_acc.sv
// dadda_mac_acc: streaming multiply-accumulate over a burst of LEN operand pairs,
// built on a 16x16 unsigned Dadda multiplier feeding a wide accumulator.
module dadda_mul (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] mul_out
);
    // Dadda height targets, largest first; the final two rows go to one adder.
    localparam int D [6] = '{13, 9, 6, 4, 3, 2};
    logic m  [32][16];
    logic nm [32][16];
    int   h  [32];
    int   nh [32];
    int   p;
    logic sum_b;
    logic cy_b;
    logic [31:0] x;
    logic [31:0] y;
    always_comb begin
        m = '{default: '{default: 1'b0}};
        nm = '{default: '{default: 1'b0}};
        h = '{default: 0};
        nh = '{default: 0};
        p = 0;
        sum_b = 1'b0;
        cy_b = 1'b0;
        x = '0;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                m[i+j][h[i+j]] = a[i] & b[j];
                h[i+j]++;
            end
        end
        for (int s = 0; s < 6; s++) begin
            nm = '{default: '{default: 1'b0}};
            nh = '{default: 0};
            for (int c = 0; c < 32; c++) begin
                p = 0;
                // Compress only the excess over the target; carries from the
                // column below already count toward this column's height.
                for (int k = 0; k < 16; k++) begin
                    if ((h[c] - p) + nh[c] > D[s]) begin
                        if ((h[c] - p) + nh[c] - D[s] >= 2) begin
                            sum_b = m[c][p] ^ m[c][p+1] ^ m[c][p+2];
                            cy_b = (m[c][p] & m[c][p+1]) | (m[c][p] & m[c][p+2]) | (m[c][p+1] & m[c][p+2]);
                            p = p + 3;
                        end else begin
                            sum_b = m[c][p] ^ m[c][p+1];
                            cy_b = m[c][p] & m[c][p+1];
                            p = p + 2;
                        end
                        nm[c][nh[c]] = sum_b;
                        nh[c]++;
                        if (c < 31) begin
                            nm[c+1][nh[c+1]] = cy_b;
                            nh[c+1]++;
                        end
                    end
                end
                for (int k = 0; k < 16; k++) begin
                    if (p < h[c]) begin
                        nm[c][nh[c]] = m[c][p];
                        nh[c]++;
                        p++;
                    end
                end
            end
            m = nm;
            h = nh;
        end
        for (int c = 0; c < 32; c++) begin
            x[c] = m[c][0];
            y[c] = m[c][1];
        end
    end
    assign mul_out = x + y;
endmodule

module dadda_mac_acc #(
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t state;
    state_t state_nxt;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] cnt_in;
    logic [LEN_W-1:0] cnt_acc;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic p1_valid;
    logic [31:0] mul_out;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0] sum;
    logic fire;
    logic begin_burst;

    dadda_mul u_mul (.a(a_r), .b(b_r), .mul_out(mul_out));

    assign in_ready = (state == ACCUM) && (cnt_in < len_r);
    assign fire = in_valid && in_ready;
    assign begin_burst = (state == IDLE) && start;
    assign sum = {1'b0, acc} + {{(ACC_W - 31){1'b0}}, mul_out};
    assign out_valid = (state == DONE);
    assign busy = (state != IDLE);
    assign acc_out = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len == '0) ? DONE : ACCUM;
            ACCUM:   if (p1_valid && cnt_acc == len_r - 1'b1) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r <= '0;
            cnt_in <= '0;
            cnt_acc <= '0;
            a_r <= '0;
            b_r <= '0;
            p1_valid <= 1'b0;
            acc <= '0;
            overflow <= 1'b0;
        end else begin
            p1_valid <= fire;
            if (fire) begin
                a_r <= a;
                b_r <= b;
                cnt_in <= cnt_in + 1'b1;
            end
            if (begin_burst) begin
                len_r <= len;
                cnt_in <= '0;
                cnt_acc <= '0;
                acc <= '0;
                overflow <= 1'b0;
            end else if (p1_valid) begin
                acc <= sum[ACC_W-1:0];
                overflow <= overflow | sum[ACC_W];
                cnt_acc <= cnt_acc + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dadda_mac_acc.sv
// tb_dadda_mac_acc: scoreboard bench driving a 40-bit and a 32-bit accumulator
// instance with identical stimulus.
module tb_dadda_mac_acc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [7:0] len = '0;
    logic in_valid = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, overflow, busy;
    logic [39:0] acc_out;
    logic in_ready_s, out_valid_s, overflow_s, busy_s;
    logic [31:0] acc_out_s;

    typedef struct {
        logic [39:0] acc;
        logic ovf;
        logic [31:0] acc_s;
        logic ovf_s;
    } exp_t;
    exp_t sb [$];
    exp_t mon_e;
    int vectors = 0;
    int errors = 0;
    logic [39:0] m_acc;
    logic m_ovf;
    logic [31:0] s_acc;
    logic s_ovf;

    always #5 clk = ~clk;

    dadda_mac_acc #(.ACC_W(40), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .overflow(overflow), .busy(busy)
    );

    dadda_mac_acc #(.ACC_W(32), .LEN_W(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
        .in_ready(in_ready_s), .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
        .acc_out(acc_out_s), .overflow(overflow_s), .busy(busy_s)
    );

    // Scoreboard consumer: compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected acc_out=%h", acc_out);
            end else begin
                mon_e = sb.pop_front();
                if (acc_out !== mon_e.acc || overflow !== mon_e.ovf || acc_out_s !== mon_e.acc_s || overflow_s !== mon_e.ovf_s || out_valid_s !== 1'b1) begin
                    errors++;
                    $display("FAIL result got acc=%h ovf=%b acc32=%h ovf32=%b v32=%b want acc=%h ovf=%b acc32=%h ovf32=%b",
                             acc_out, overflow, acc_out_s, overflow_s, out_valid_s, mon_e.acc, mon_e.ovf, mon_e.acc_s, mon_e.ovf_s);
                end
            end
        end
    end

    task automatic push_expect();
        exp_t e;
        e.acc = m_acc;
        e.ovf = m_ovf;
        e.acc_s = s_acc;
        e.ovf_s = s_ovf;
        sb.push_back(e);
    endtask

    task automatic begin_burst(input int l);
        @(posedge clk);
        #1 start = 1'b1;
        len = 8'(l);
        m_acc = '0;
        m_ovf = 1'b0;
        s_acc = '0;
        s_ovf = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        if (l == 0) push_expect();
    endtask

    task automatic xfer(input logic [15:0] x, input logic [15:0] y, input logic last);
        logic ok;
        logic [31:0] p;
        logic [40:0] t40;
        logic [32:0] t32;
        ok = 1'b0;
        in_valid = 1'b1;
        a = x;
        b = y;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) begin
            vectors++;
            errors++;
            $display("FAIL xfer_timeout in_ready=%b want 1", in_ready);
        end else begin
            p = {16'b0, x} * {16'b0, y};
            t40 = {1'b0, m_acc} + {9'b0, p};
            m_acc = t40[39:0];
            m_ovf = m_ovf | t40[40];
            t32 = {1'b0, s_acc} + {1'b0, p};
            s_acc = t32[31:0];
            s_ovf = s_ovf | t32[32];
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (last) push_expect();
    endtask

    task automatic wait_done(input int hold);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            ok = out_valid;
        end
        if (!ok) begin
            vectors++;
            errors++;
            $display("FAIL done_timeout out_valid=%b want 1", out_valid);
        end
        repeat (hold) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, acc_out, overflow, busy, in_ready_s, out_valid_s, acc_out_s, overflow_s, busy_s} !== '0) begin
            errors++;
            $display("FAIL reset_outputs rdy=%b ov=%b acc=%h ovf=%b busy=%b acc32=%h want all 0", in_ready, out_valid, acc_out, overflow, busy, acc_out_s);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single();
        begin_burst(1);
        xfer(16'd3, 16'd5, 1'b1);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_latency_early out_valid=%b busy=%b want 0 1", out_valid, busy);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || acc_out !== 40'd15 || overflow !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_result out_valid=%b acc=%h ovf=%b busy=%b want 1 f 0 1", out_valid, acc_out, overflow, busy);
        end
        wait_done(0);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle busy=%b out_valid=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        begin_burst(4);
        for (int i = 0; i < 4; i++) xfer(16'hFFFF, 16'hFFFF, i == 3);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_in_ready got %b want 0", in_ready);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || acc_out !== 40'h3_FFF8_0004 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result out_valid=%b acc=%h ovf=%b want 1 3fff80004 0", out_valid, acc_out, overflow);
        end
        wait_done(2);
    endtask

    task automatic test_zero_len();
        begin_burst(0);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || acc_out !== 40'd0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_len out_valid=%b acc=%h in_ready=%b busy=%b want 1 0 0 1", out_valid, acc_out, in_ready, busy);
        end
        wait_done(1);
    endtask

    task automatic test_flow();
        begin_burst(3);
        xfer(16'd2, 16'd2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        xfer(16'd3, 16'd3, 1'b0);
        @(posedge clk);
        #1;
        xfer(16'd4, 16'd4, 1'b1);
        in_valid = 1'b1;
        a = 16'd9;
        b = 16'd9;
        start = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flow_extra in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || acc_out !== 40'd29 || busy !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL flow_hold cyc=%0d out_valid=%b acc=%h busy=%b in_ready=%b want 1 1d 1 0", i, out_valid, acc_out, busy, in_ready);
            end
            @(posedge clk);
            #1 start = (i == 1);
        end
        in_valid = 1'b0;
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        out_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flow_start_ignored busy=%b out_valid=%b want 0 0", busy, out_valid);
            end
        end
    endtask

    task automatic test_overflow();
        begin_burst(2);
        xfer(16'hFFFF, 16'hFFFF, 1'b0);
        xfer(16'hFFFF, 16'hFFFF, 1'b1);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (acc_out_s !== 32'hFFFC_0002 || overflow_s !== 1'b1 || acc_out !== 40'h1_FFFC_0002 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_wrap acc32=%h ovf32=%b acc=%h ovf=%b want fffc0002 1 1fffc0002 0", acc_out_s, overflow_s, acc_out, overflow);
        end
        wait_done(0);
        begin_burst(1);
        @(negedge clk);
        vectors++;
        if (overflow_s !== 1'b0 || acc_out_s !== 32'd0) begin
            errors++;
            $display("FAIL overflow_clear ovf32=%b acc32=%h want 0 0", overflow_s, acc_out_s);
        end
        @(posedge clk);
        #1;
        xfer(16'd1, 16'd1, 1'b1);
        wait_done(0);
    endtask

    task automatic test_reset_mid();
        begin_burst(4);
        xfer(16'd100, 16'd200, 1'b0);
        xfer(16'd300, 16'd400, 1'b0);
        in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, acc_out, overflow, busy, acc_out_s, busy_s} !== '0) begin
            errors++;
            $display("FAIL reset_mid rdy=%b ov=%b acc=%h ovf=%b busy=%b want all 0", in_ready, out_valid, acc_out, overflow, busy);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        begin_burst(1);
        xfer(16'd7, 16'd9, 1'b1);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (acc_out !== 40'd63 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_residue acc=%h out_valid=%b want 3f 1", acc_out, out_valid);
        end
        wait_done(0);
    endtask

    task automatic test_random();
        int l;
        for (int n = 0; n < 6; n++) begin
            l = $urandom_range(1, 6);
            begin_burst(l);
            for (int i = 0; i < l; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    @(posedge clk);
                    #1;
                end
                xfer(16'($urandom), 16'($urandom), i == l - 1);
            end
            wait_done($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_len();
        test_flow();
        test_overflow();
        test_reset_mid();
        test_random();
        repeat (3) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
